nios_system_nios2_div_cell: RTL and testbench

NIOS_SYSTEM_NIOS2_DIV_CELL -- requirements
Module: nios_system_nios2_div_cell

---
 rtl/nios_system_nios2_div_cell.sv | 204 ++++++++++++++++++++
 tb/tb_nios_system_nios2_div_cell.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_nios2_div_cell.sv
// nios_system_nios2_div_cell
// 32-bit radix-2 restoring divider. It handles signed and unsigned operands
// and produces one quotient bit per clock.
// A start in IDLE runs 32 CALC iterations, then a FIX cycle that applies the
// signs, then a DONE cycle. The result is flagged by a one-cycle done pulse.
// Optional build macro: NIOS2_DIV_EARLY_OUT_EN. When it is defined, a zero
// divisor skips the iterations and reports done one edge after start.
module nios_system_nios2_div_cell (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        E_div_start,
  input  logic        E_ctrl_div_signed,
  input  logic [31:0] E_src1_div_cell,
  input  logic [31:0] E_src2_div_cell,
  input  logic        E_div_abort,
  output logic [31:0] M_div_cell_result,
  output logic [31:0] M_div_cell_remainder,
  output logic        M_div_cell_busy,
  output logic        M_div_cell_done,
  output logic        M_div_cell_div_by_zero
);

`ifdef NIOS2_DIV_EARLY_OUT_EN
  localparam logic EARLY_OUT = 1'b1;
`else
  localparam logic EARLY_OUT = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // quo_q shifts the dividend magnitude out of its MSB and the quotient bits
  // into its LSB, so a single register serves both roles.
  logic [31:0] quo_q, quo_d;
  logic [31:0] prem_q, prem_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [31:0] dvnd_q, dvnd_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        zero_q, zero_d;
  logic [31:0] result_q, result_d;
  logic [31:0] remainder_q, remainder_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;

  logic        src1_neg, src2_neg;
  logic [31:0] src1_mag, src2_mag;
  logic [32:0] shifted;
  logic [31:0] diff;
  logic        step_ok;
  logic [31:0] quo_fix, rem_fix;

  // Operand signs and magnitudes. The magnitude of 0x80000000 is itself
  // when the bits are read as unsigned, so it needs no special case.
  assign src1_neg = E_ctrl_div_signed & E_src1_div_cell[31];
  assign src2_neg = E_ctrl_div_signed & E_src2_div_cell[31];
  assign src1_mag = src1_neg ? (~E_src1_div_cell + 32'd1) : E_src1_div_cell;
  assign src2_mag = src2_neg ? (~E_src2_div_cell + 32'd1) : E_src2_div_cell;

  // One restoring step uses a 33-bit shifted partial remainder.
  // When the trial subtract fits, the difference is below the divisor, so
  // the low 32 bits of the subtraction are exact.
  assign shifted = {prem_q, quo_q[31]};
  assign step_ok = (shifted >= {1'b0, dvsr_q});
  assign diff    = shifted[31:0] - dvsr_q;

  // Sign correction applied in FIX.
  assign quo_fix = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
  assign rem_fix = neg_rem_q ? (~prem_q + 32'd1) : prem_q;

  // Next-state logic and datapath updates. Abort overrides everything at the end.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    prem_d      = prem_q;
    dvsr_d      = dvsr_q;
    dvnd_d      = dvnd_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    zero_d      = zero_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (E_div_start) begin
          quo_d     = src1_mag;
          dvsr_d    = src2_mag;
          dvnd_d    = E_src1_div_cell;
          prem_d    = 32'd0;
          neg_quo_d = src1_neg ^ src2_neg;
          neg_rem_d = src1_neg;
          zero_d    = (E_src2_div_cell == 32'd0);
          cnt_d     = 6'd0;
          state_d   = S_CALC;
        end
      end

      S_CALC: begin
        if (EARLY_OUT && zero_q) begin
          // Zero divisor: the outcome is fixed, so the iterations are skipped.
          result_d    = 32'hFFFF_FFFF;
          remainder_d = dvnd_q;
          dbz_d       = 1'b1;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end else begin
          quo_d  = {quo_q[30:0], step_ok};
          prem_d = step_ok ? diff : shifted[31:0];
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        if (zero_q) begin
          // Zero divisor: the sign correction would corrupt the fixed
          // results, so they are forced instead.
          result_d    = 32'hFFFF_FFFF;
          remainder_d = dvnd_q;
        end else begin
          result_d    = quo_fix;
          remainder_d = rem_fix;
        end
        dbz_d   = zero_q;
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (E_div_abort) begin
      state_d     = S_IDLE;
      cnt_d       = 6'd0;
      done_d      = 1'b0;
      result_d    = result_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers. Reset is asynchronous and active low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 6'd0;
      quo_q       <= 32'd0;
      prem_q      <= 32'd0;
      dvsr_q      <= 32'd0;
      dvnd_q      <= 32'd0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      zero_q      <= 1'b0;
      result_q    <= 32'd0;
      remainder_q <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      prem_q      <= prem_d;
      dvsr_q      <= dvsr_d;
      dvnd_q      <= dvnd_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      zero_q      <= zero_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  assign M_div_cell_result      = result_q;
  assign M_div_cell_remainder   = remainder_q;
  assign M_div_cell_busy        = busy_q;
  assign M_div_cell_done        = done_q;
  assign M_div_cell_div_by_zero = dbz_q;

endmodule

// File: tb/tb_nios_system_nios2_div_cell.sv
// Testbench for nios_system_nios2_div_cell.
// The bench runs directed corner cases and then randomized divides. It
// compares each result against an arithmetic reference model. It also
// exercises abort, an ignored start, start with abort, and asynchronous reset.
module tb_nios_system_nios2_div_cell;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        sgn;
  logic        abort;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] result;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        dbz;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] last_q;
  logic [31:0] last_r;

  nios_system_nios2_div_cell dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .E_div_start            (start),
    .E_ctrl_div_signed      (sgn),
    .E_src1_div_cell        (src1),
    .E_src2_div_cell        (src2),
    .E_div_abort            (abort),
    .M_div_cell_result      (result),
    .M_div_cell_remainder   (remainder),
    .M_div_cell_busy        (busy),
    .M_div_cell_done        (done),
    .M_div_cell_div_by_zero (dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model. Signed division runs on 64-bit integers, so the
  // overflow case 0x80000000 / -1 wraps naturally to 0x80000000.
  function automatic void ref_div(input logic s, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sx;
    longint sy;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = 32'(sx / sy);
      r  = 32'(sx % sy);
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  function automatic int exp_lat(input logic [31:0] y);
`ifdef NIOS2_DIV_EARLY_OUT_EN
    return (y == 32'd0) ? 1 : 33;
`else
    return (y == 32'd0) ? 33 : 33;
`endif
  endfunction

  // One divide from start to idle. When poke is set, a start with other
  // operands is also presented at edge k+5; it must be ignored.
  task automatic do_div(input string tag, input logic s, input logic [31:0] x,
                        input logic [31:0] y, input bit poke);
    logic [31:0] eq;
    logic [31:0] er;
    int n;
    ref_div(s, x, y, eq, er);
    @(negedge clk);
    start = 1'b1; sgn = s; src1 = x; src2 = y;
    @(negedge clk);  // edge k has passed
    start = 1'b0; src1 = $urandom; src2 = $urandom; sgn = 1'($urandom_range(0, 1));
    check($sformatf("%s busy_after_start", tag), 32'(busy), 32'd1);
    n = 0;
    do begin
      start = (poke && n == 4);
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    start = 1'b0;
    check($sformatf("%s latency", tag), n, exp_lat(y));
    check($sformatf("%s quotient", tag), result, eq);
    check($sformatf("%s remainder", tag), remainder, er);
    check($sformatf("%s div_by_zero", tag), 32'(dbz), 32'(y == 32'd0));
    @(negedge clk);
    check($sformatf("%s done_one_cycle", tag), 32'(done), 32'd0);
    check($sformatf("%s busy_released", tag), 32'(busy), 32'd0);
    $display("op %s signed=%0d %h / %h -> q=%h r=%h dbz=%0d lat=%0d",
             tag, s, x, y, result, remainder, dbz, n);
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    int first_done;
    int kind;
    logic [31:0] x;
    logic [31:0] y;
    logic        s;
    logic [31:0] eq;
    logic [31:0] er;

    reset_n = 1'b1; start = 1'b0; abort = 1'b0; sgn = 1'b0; src1 = '0; src2 = '0;
    #1 reset_n = 1'b0;
    #1;
    check("reset result", result, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset dbz", 32'(dbz), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed corner cases
    do_div("u100_7", 1'b0, 32'd100, 32'd7, 1'b0);
    do_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_div("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_div("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_div("u5_0", 1'b0, 32'd5, 32'd0, 1'b0);
    do_div("s_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0);
    do_div("poke", 1'b1, 32'd1000, 32'hFFFF_FFFD, 1'b1);

    // Abort at k+10, then a new start at k+12 that must finish at k+45
    ref_div(1'b0, 32'd12345, 32'd67, eq, er);
    @(negedge clk);
    start = 1'b1; sgn = 1'b1; src1 = 32'hDEAD_BEEF; src2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    first_done = -1;
    for (int n = 1; n <= 50; n++) begin
      abort = (n == 10);
      start = (n == 12);
      if (n == 12) begin
        sgn = 1'b0; src1 = 32'd12345; src2 = 32'd67;
      end
      @(negedge clk);
      if (done && first_done < 0) first_done = n;
      if (n == 11) begin
        check("abort busy_cleared", 32'(busy), 32'd0);
        check("abort result_held", result, last_q);
        check("abort remainder_held", remainder, last_r);
      end
    end
    abort = 1'b0; start = 1'b0;
    check("abort second_done_edge", first_done, 32'd45);
    check("abort second_quotient", result, eq);
    check("abort second_remainder", remainder, er);
    $display("op abort_restart first_done=%0d q=%h r=%h", first_done, result, remainder);

    // Start and abort at the same edge: the start is dropped
    @(negedge clk);
    start = 1'b1; abort = 1'b1; sgn = 1'b0; src1 = 32'd9; src2 = 32'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort busy", 32'(busy), 32'd0);
    first_done = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done && first_done < 0) first_done = n;
    end
    check("start_abort no_done", first_done, 32'hFFFF_FFFF);
    $display("op start_with_abort first_done=%0d", first_done);

    // Asynchronous reset mid-operation
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; src1 = 32'd777; src2 = 32'd5;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n < 20; n++) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midreset result", result, 32'd0);
    check("midreset remainder", remainder, 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset dbz", 32'(dbz), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    first_done = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done && first_done < 0) first_done = n;
    end
    check("midreset no_done", first_done, 32'hFFFF_FFFF);
    $display("op midreset first_done=%0d", first_done);
    do_div("after_reset", 1'b1, 32'hFFFF_FC18, 32'd7, 1'b0);

    // Randomized divides
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 5);
      s = 1'($urandom_range(0, 1));
      x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case (kind)
        0:       y = 32'd0;
        1:       y = 32'($urandom_range(1, 15));
        2:       y = 32'hFFFF_FFFF;
        3:       y = 32'($urandom) >> $urandom_range(0, 31);
        default: y = 32'($urandom);
      endcase
      do_div($sformatf("rnd%0d", i), s, x, y, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
